mac_seq: RTL and testbench

- Sequencer that sits between an operand-pair stream and the shared sequential multiplier `mul`.
- Each accepted pair is issued to `mul` via its start/busy handshake, and the 16-bit product is summed into an accumulator.
- When the pair tagged `last` completes, the sum and element count are presented on an output valid/ready port.
- Used as the dot-product / MAC front end for the datapath.

---
 rtl/mac_pkg.sv | 17 +
 rtl/mac_seq_if.sv | 32 +++
 rtl/mac_acc.sv | 37 +++
 rtl/mul.sv | 46 ++++
 rtl/mac_seq.sv | 113 +++++++++++
 tb/tb_mac_seq.sv | 292 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the mac_seq slice: FSM state encodings and default widths.
package mac_pkg;

  localparam int DEF_W        = 8;
  localparam int DEF_ACC_W    = 24;
  localparam int DEF_CNT_W    = 8;
  localparam int DEF_MAX_WAIT = 2000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/mac_seq_if.sv
// Operand-pair input stream and accumulated-result output port of mac_seq.
interface mac_seq_if
  import mac_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;
  logic             err_o;

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_acc, out_cnt, out_ovf, err_o
  );

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_acc, out_cnt, out_ovf, err_o
  );

endinterface

// File: rtl/mac_acc.sv
// Registered accumulator: adds a zero-extended product, flags carry-out as a
// sticky overflow, counts terms with saturation, and clears synchronously.
module mac_acc #(
  parameter int W     = 8,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             add,
  input  logic             clr,
  input  logic [2*W-1:0]   prod,
  output logic [ACC_W-1:0] acc,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  logic [ACC_W:0] sum;

  // Extra top bit captures the carry that marks a wrap of the accumulator.
  assign sum = {1'b0, acc} + {{(ACC_W + 1 - 2*W){1'b0}}, prod};

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (add) begin
      acc <= sum[ACC_W-1:0];
      if (sum[ACC_W]) ovf <= 1'b1;
      if (cnt != '1) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mul.sv
// Shared sequential shift-add multiplier: start pulse loads operands, busy is
// high for W cycles, result is the 2*W-bit product once busy falls.
module mul #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  input  logic           start,
  output logic [2*W-1:0] result,
  output logic           busy
);

  localparam int NW = $clog2(W + 1);

  logic [2*W-1:0] mcand;
  logic [2*W-1:0] prod;
  logic [W-1:0]   mplier;
  logic [NW-1:0]  steps;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
      steps  <= '0;
      busy   <= 1'b0;
    end else if (start && !busy) begin
      mcand  <= {{W{1'b0}}, a_i};
      mplier <= b_i;
      prod   <= '0;
      steps  <= NW'(W);
      busy   <= 1'b1;
    end else if (busy) begin
      if (mplier[0]) prod <= prod + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      steps  <= steps - 1'b1;
      if (steps == NW'(1)) busy <= 1'b0;
    end
  end

  assign result = prod;

endmodule

// File: rtl/mac_seq.sv
// MAC sequencer: issues each accepted operand pair to the shared multiplier and
// sums the products. Optional watchdog on the multiplier wait: MAC_TIMEOUT_EN.
module mac_seq
  import mac_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic           clk,
  input  logic           rst,
  mac_seq_if.slave       bus,
  output logic [W-1:0]   mul_a_o,
  output logic [W-1:0]   mul_b_o,
  output logic           mul_start_o,
  input  logic [2*W-1:0] mul_result_i,
  input  logic           mul_busy_i
);

  state_e       state;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         last_q;
  logic         start_q;
  logic         acc_add;
  logic         acc_clr;
  logic         timeout;

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign mul_a_o       = a_q;
  assign mul_b_o       = b_q;
  assign mul_start_o   = start_q;
  assign acc_add       = (state == ST_WAIT) && !mul_busy_i;
  assign acc_clr       = (state == ST_DONE) && bus.out_ready;

  mac_acc #(
    .W     (W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_acc (
    .clk  (clk),
    .rst  (rst),
    .add  (acc_add),
    .clr  (acc_clr),
    .prod (mul_result_i),
    .acc  (bus.out_acc),
    .cnt  (bus.out_cnt),
    .ovf  (bus.out_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      last_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.in_a;
            b_q     <= bus.in_b;
            last_q  <= bus.in_last;
            start_q <= 1'b1;
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE:  state <= ST_SETTLE;
        // The multiplier's busy is not meaningful until one cycle after start.
        ST_SETTLE: state <= ST_WAIT;
        ST_WAIT: begin
          if (!mul_busy_i)  state <= last_q ? ST_DONE : ST_IDLE;
          else if (timeout) state <= ST_DONE;
        end
        ST_DONE: if (bus.out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MAC_TIMEOUT_EN
  localparam int TW = $clog2(MAX_WAIT + 1);

  logic [TW-1:0] wait_cnt;
  logic          err_q;

  assign timeout   = mul_busy_i && (wait_cnt == TW'(MAX_WAIT - 1));
  assign bus.err_o = err_q;

  // Counts SETTLE+WAIT cycles; the MAX_WAIT-th such cycle with busy high aborts.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == ST_ISSUE) wait_cnt <= '0;
      else if (state == ST_SETTLE || state == ST_WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (state == ST_WAIT && timeout) err_q <= 1'b1;
      else if (acc_clr)                err_q <= 1'b0;
    end
  end
`else
  wire unused_max_wait = (MAX_WAIT > 0);

  assign timeout   = 1'b0;
  assign bus.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_mac_seq.sv
// Scoreboard bench for mac_seq with the real mul (24- and 16-bit accumulators)
// plus a stuck-busy multiplier stub for the watchdog path.
module tb_mac_seq;

  typedef struct {
    logic [31:0] acc;
    logic [31:0] cnt;
    logic        ovf;
    logic        err;
  } exp_t;

  logic clk;
  logic rst0, rst1, rst2;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t sb0[$];
  exp_t sb1[$];

  int start_cnt0   = 0;
  int double_start = 0;
  int busy_start   = 0;
  logic prev_start0 = 1'b0;

  mac_seq_if #(.W(8), .ACC_W(24), .CNT_W(8)) if0 ();
  mac_seq_if #(.W(8), .ACC_W(16), .CNT_W(8)) if1 ();
  mac_seq_if #(.W(8), .ACC_W(24), .CNT_W(8)) if2 ();

  logic [7:0]  mul_a0, mul_b0, mul_a1, mul_b1, mul_a2, mul_b2;
  logic        mul_start0, mul_start1, mul_start2;
  logic [15:0] mul_res0, mul_res1;
  logic        mul_busy0, mul_busy1;
  logic [15:0] stub_res;
  logic        stub_busy;

  assign stub_res  = 16'd0;
  assign stub_busy = 1'b1;

  mac_seq #(.W(8), .ACC_W(24), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst0), .bus(if0),
    .mul_a_o(mul_a0), .mul_b_o(mul_b0), .mul_start_o(mul_start0),
    .mul_result_i(mul_res0), .mul_busy_i(mul_busy0)
  );
  mul #(.W(8)) m0 (
    .clk(clk), .rst(rst0), .a_i(mul_a0), .b_i(mul_b0),
    .start(mul_start0), .result(mul_res0), .busy(mul_busy0)
  );

  mac_seq #(.W(8), .ACC_W(16), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst1), .bus(if1),
    .mul_a_o(mul_a1), .mul_b_o(mul_b1), .mul_start_o(mul_start1),
    .mul_result_i(mul_res1), .mul_busy_i(mul_busy1)
  );
  mul #(.W(8)) m1 (
    .clk(clk), .rst(rst1), .a_i(mul_a1), .b_i(mul_b1),
    .start(mul_start1), .result(mul_res1), .busy(mul_busy1)
  );

  mac_seq #(.W(8), .ACC_W(24), .CNT_W(8), .MAX_WAIT(10)) u2 (
    .clk(clk), .rst(rst2), .bus(if2),
    .mul_a_o(mul_a2), .mul_b_o(mul_b2), .mul_start_o(mul_start2),
    .mul_result_i(stub_res), .mul_busy_i(stub_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic push0(input int acc, input int cnt, input logic ovf);
    exp_t e;
    e.acc = 32'(acc); e.cnt = 32'(cnt); e.ovf = ovf; e.err = 1'b0;
    sb0.push_back(e);
  endtask

  task automatic push1(input int acc, input int cnt, input logic ovf);
    exp_t e;
    e.acc = 32'(acc); e.cnt = 32'(cnt); e.ovf = ovf; e.err = 1'b0;
    sb1.push_back(e);
  endtask

  // Monitors: pop and compare whenever a result is handed over.
  always @(negedge clk) begin
    exp_t e;
    if (!rst0 && if0.out_valid && if0.out_ready) begin
      if (sb0.size() == 0) begin
        n_checks++;
        $display("FAIL u0_unexpected_result: got acc=%0d, expected no result", if0.out_acc);
      end else begin
        e = sb0.pop_front();
        check("u0_acc", 32'(if0.out_acc), e.acc);
        check("u0_cnt", 32'(if0.out_cnt), e.cnt);
        check("u0_ovf", 32'(if0.out_ovf), 32'(e.ovf));
        check("u0_err", 32'(if0.err_o),   32'(e.err));
      end
    end
    if (mul_start0) begin
      start_cnt0++;
      if (prev_start0) double_start++;
      if (mul_busy0)   busy_start++;
    end
    prev_start0 = mul_start0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst1 && if1.out_valid && if1.out_ready) begin
      if (sb1.size() == 0) begin
        n_checks++;
        $display("FAIL u1_unexpected_result: got acc=%0d, expected no result", if1.out_acc);
      end else begin
        e = sb1.pop_front();
        check("u1_acc", 32'(if1.out_acc), e.acc);
        check("u1_cnt", 32'(if1.out_cnt), e.cnt);
        check("u1_ovf", 32'(if1.out_ovf), 32'(e.ovf));
        check("u1_err", 32'(if1.err_o),   32'(e.err));
      end
    end
  end

  task automatic send0(input logic [7:0] a, input logic [7:0] b, input logic last);
    logic rdy;
    logic done = 1'b0;
    if0.in_valid = 1'b1; if0.in_a = a; if0.in_b = b; if0.in_last = last;
    for (int i = 0; i < 200 && !done; i++) begin
      rdy = if0.in_ready;
      @(posedge clk); #1;
      if (rdy) done = 1'b1;
    end
    if0.in_valid = 1'b0;
    check("u0_accept", 32'(done), 32'd1);
  endtask

  task automatic send1(input logic [7:0] a, input logic [7:0] b, input logic last);
    logic rdy;
    logic done = 1'b0;
    if1.in_valid = 1'b1; if1.in_a = a; if1.in_b = b; if1.in_last = last;
    for (int i = 0; i < 200 && !done; i++) begin
      rdy = if1.in_ready;
      @(posedge clk); #1;
      if (rdy) done = 1'b1;
    end
    if1.in_valid = 1'b0;
    check("u1_accept", 32'(done), 32'd1);
  endtask

  task automatic drain0();
    for (int i = 0; i < 300 && (sb0.size() != 0 || if0.out_valid); i++) begin
      @(posedge clk); #1;
    end
    check("u0_drain", 32'(sb0.size()), 32'd0);
  endtask

  task automatic drain1();
    for (int i = 0; i < 300 && (sb1.size() != 0 || if1.out_valid); i++) begin
      @(posedge clk); #1;
    end
    check("u1_drain", 32'(sb1.size()), 32'd0);
  endtask

  initial begin
    int starts;
    int cycles;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    if0.in_valid = 1'b0; if0.in_a = '0; if0.in_b = '0; if0.in_last = 1'b0; if0.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.in_a = '0; if1.in_b = '0; if1.in_last = 1'b0; if1.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.in_a = '0; if2.in_b = '0; if2.in_last = 1'b0; if2.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    // Reset state
    check("rst_in_ready",  32'(if0.in_ready),  32'd1);
    check("rst_out_valid", 32'(if0.out_valid), 32'd0);
    check("rst_acc",       32'(if0.out_acc),   32'd0);
    check("rst_cnt",       32'(if0.out_cnt),   32'd0);
    check("rst_ovf",       32'(if0.out_ovf),   32'd0);
    check("rst_err",       32'(if0.err_o),     32'd0);
    check("rst_start",     32'(mul_start0),    32'd0);

    // Single pair
    starts = start_cnt0;
    push0(6, 1, 1'b0);
    send0(8'd3, 8'd2, 1'b1);
    drain0();
    check("single_starts", 32'(start_cnt0 - starts), 32'd1);

    // Three-pair vector held in DONE by backpressure
    starts = start_cnt0;
    if0.out_ready = 1'b0;
    push0(43, 3, 1'b0);
    send0(8'd3, 8'd2, 1'b0);
    send0(8'd5, 8'd5, 1'b0);
    send0(8'd4, 8'd3, 1'b1);
    for (int i = 0; i < 100 && !if0.out_valid; i++) begin
      @(posedge clk); #1;
    end
    check("vec_valid", 32'(if0.out_valid), 32'd1);
    check("vec_starts", 32'(start_cnt0 - starts), 32'd3);
    if0.in_valid = 1'b1; if0.in_a = 8'd9; if0.in_b = 8'd9; if0.in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid",    32'(if0.out_valid), 32'd1);
      check("bp_acc",      32'(if0.out_acc),   32'd43);
      check("bp_in_ready", 32'(if0.in_ready),  32'd0);
      @(posedge clk); #1;
    end
    if0.in_valid = 1'b0;
    if0.out_ready = 1'b1;
    drain0();
    check("clr_acc", 32'(if0.out_acc), 32'd0);
    check("clr_cnt", 32'(if0.out_cnt), 32'd0);
    check("bp_ignored_starts", 32'(start_cnt0 - starts), 32'd3);

    // Reset while the second pair waits on the multiplier
    send0(8'd3, 8'd2, 1'b0);
    send0(8'd5, 8'd5, 1'b1);
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("mid_busy", 32'(mul_busy0), 32'd1);
    rst0 = 1'b1;
    @(posedge clk); #1;
    rst0 = 1'b0;
    check("mid_in_ready",  32'(if0.in_ready),  32'd1);
    check("mid_out_valid", 32'(if0.out_valid), 32'd0);
    check("mid_start",     32'(mul_start0),    32'd0);
    check("mid_acc",       32'(if0.out_acc),   32'd0);
    push0(12, 1, 1'b0);
    send0(8'd4, 8'd3, 1'b1);
    drain0();

    // Overflow on the 16-bit accumulator, then a clean vector
    push1(64514, 2, 1'b1);
    send1(8'd255, 8'd255, 1'b0);
    send1(8'd255, 8'd255, 1'b1);
    drain1();
    push1(1, 1, 1'b0);
    send1(8'd1, 8'd1, 1'b1);
    drain1();

    // Multiplier stuck busy
    if2.in_valid = 1'b1; if2.in_a = 8'd1; if2.in_b = 8'd1; if2.in_last = 1'b1;
    @(posedge clk); #1;
    if2.in_valid = 1'b0;
    check("stub_start", 32'(mul_start2), 32'd1);
`ifdef MAC_TIMEOUT_EN
    cycles = 0;
    for (int i = 0; i < 60 && !if2.out_valid; i++) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("to_valid",  32'(if2.out_valid), 32'd1);
    check("to_cycles", 32'(cycles),        32'd11);
    check("to_err",    32'(if2.err_o),     32'd1);
    check("to_cnt",    32'(if2.out_cnt),   32'd0);
    check("to_acc",    32'(if2.out_acc),   32'd0);
`else
    cycles = 0;
    repeat (50) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("nt_cycles",    32'(cycles),        32'd50);
    check("nt_out_valid", 32'(if2.out_valid), 32'd0);
    check("nt_in_ready",  32'(if2.in_ready),  32'd0);
    check("nt_err",       32'(if2.err_o),     32'd0);
`endif

    check("start_double",    32'(double_start), 32'd0);
    check("start_when_busy", 32'(busy_start),   32'd0);
    check("sb0_empty",       32'(sb0.size()),   32'd0);
    check("sb1_empty",       32'(sb1.size()),   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
